// File: rtl/mips_pkg.sv
// Shared MIPS definitions: opcode/funct constants, control-field encodings,
// multi-cycle controller states and the per-state control decode.
package mips_pkg;

    localparam logic [5:0] OP_R_FORMAT = 6'd0;
    localparam logic [5:0] OP_LW       = 6'd35;
    localparam logic [5:0] OP_SW       = 6'd43;
    localparam logic [5:0] OP_BEQ      = 6'd4;
    localparam logic [5:0] OP_J        = 6'd2;
    localparam logic [5:0] OP_ADDIU    = 6'd9;
    localparam logic [5:0] OP_BGTZ     = 6'd7;

    localparam logic [5:0] FN_SLL = 6'd0;
    localparam logic [5:0] FN_SRL = 6'd2;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    localparam logic [1:0] SRCB_B       = 2'b00;
    localparam logic [1:0] SRCB_FOUR    = 2'b01;
    localparam logic [1:0] SRCB_IMM     = 2'b10;
    localparam logic [1:0] SRCB_IMM_SH2 = 2'b11;

    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

    localparam logic [1:0] BR_NONE = 2'b00;
    localparam logic [1:0] BR_EQ   = 2'b01;
    localparam logic [1:0] BR_GTZ  = 2'b10;

    typedef enum logic [3:0] {
        S_RST    = 4'd0,
        S_FETCH  = 4'd1,
        S_DECODE = 4'd2,
        S_REXEC  = 4'd3,
        S_RWB    = 4'd4,
        S_MEMADR = 4'd5,
        S_MEMRD  = 4'd6,
        S_MEMWB  = 4'd7,
        S_MEMWR  = 4'd8,
        S_BRANCH = 4'd9,
        S_JUMP   = 4'd10,
        S_IEXEC  = 4'd11,
        S_IWB    = 4'd12,
        S_ERR    = 4'd15
    } state_t;

    typedef struct packed {
        logic       fetch;
        logic       pcwrite;
        logic       pcwritecond;
        logic [1:0] brtype;
        logic       iord;
        logic       memread;
        logic       memwrite;
        logic       regdst;
        logic       memtoreg;
        logic       regwrite;
        logic       alusrca;
        logic [1:0] alusrcb;
        logic [1:0] aluop;
        logic [1:0] pcsource;
        logic       shamt;
        logic       err;
    } ctrl_t;

    function automatic logic is_wait_state(input state_t s);
        return (s == S_FETCH) || (s == S_MEMRD) || (s == S_MEMWR);
    endfunction

    // Write-back states repeat the ALU setup of their execute state so ALUOut stays meaningful.
    function automatic ctrl_t decode_ctrl(input state_t s, input logic [5:0] op, input logic [5:0] fn);
        ctrl_t c;
        c = '0;
        case (s)
            S_FETCH: begin
                c.fetch    = 1'b1;
                c.memread  = 1'b1;
                c.alusrcb  = SRCB_FOUR;
                c.aluop    = ALUOP_ADD;
                c.pcsource = PCSRC_ALU;
            end
            S_DECODE: c.alusrcb = SRCB_IMM_SH2;
            S_REXEC, S_RWB: begin
                c.alusrca = 1'b1;
                c.aluop   = ALUOP_FUNCT;
                if (fn == FN_SLL || fn == FN_SRL) begin
                    c.shamt   = 1'b1;
                    c.alusrcb = SRCB_IMM;
                end else begin
                    c.alusrcb = SRCB_B;
                end
                if (s == S_RWB) begin
                    c.regdst   = 1'b1;
                    c.regwrite = 1'b1;
                end
            end
            S_MEMADR, S_IEXEC, S_IWB: begin
                c.alusrca  = 1'b1;
                c.alusrcb  = SRCB_IMM;
                c.aluop    = ALUOP_ADD;
                c.regwrite = (s == S_IWB);
            end
            S_MEMRD: begin
                c.memread = 1'b1;
                c.iord    = 1'b1;
            end
            S_MEMWB: begin
                c.memtoreg = 1'b1;
                c.regwrite = 1'b1;
            end
            S_MEMWR: begin
                c.memwrite = 1'b1;
                c.iord     = 1'b1;
            end
            S_BRANCH: begin
                c.alusrca     = 1'b1;
                c.alusrcb     = SRCB_B;
                c.aluop       = ALUOP_SUB;
                c.pcwritecond = 1'b1;
                c.pcsource    = PCSRC_ALUOUT;
                c.brtype      = (op == OP_BGTZ) ? BR_GTZ : BR_EQ;
            end
            S_JUMP: begin
                c.pcwrite  = 1'b1;
                c.pcsource = PCSRC_JUMP;
            end
            S_ERR:   c.err = 1'b1;
            default: c = '0;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/mem_wait_timer.sv
// Counts stalled cycles while the controller waits on mem_ready and flags
// the cycle on which the stall budget runs out.
module mem_wait_timer #(
    parameter int MEM_TIMEOUT = 15,
    parameter int TOW         = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic waiting,
    input  logic clear,
    input  logic mem_ready,
    output logic timeout
);

    logic [TOW-1:0] count;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            count <= '0;
        else if (clear || mem_ready || !waiting)
            count <= '0;
        else
            count <= count + TOW'(1);
    end

    // A ready on the final allowed cycle still counts as a normal completion.
    assign timeout = waiting && !mem_ready && (count == TOW'(MEM_TIMEOUT - 1));

endmodule

// File: rtl/control_multi.sv
// Multi-cycle MIPS control FSM: sequences each instruction through its states,
// stalls on the memory handshake and locks up in ERR on bad opcodes or timeouts.
module control_multi
    import mips_pkg::*;
#(
    parameter int OPW         = 6,
    parameter int ALUOPW      = 2,
    parameter int MEM_TIMEOUT = 15,
    parameter int TOW         = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [OPW-1:0]    opcode,
    input  logic [OPW-1:0]    funct,
    input  logic              instr_nop,
    input  logic              mem_ready,
    output logic              PCWrite,
    output logic              PCWriteCond,
    output logic [1:0]        BrType,
    output logic              IorD,
    output logic              MemRead,
    output logic              MemWrite,
    output logic              IRWrite,
    output logic              RegDst,
    output logic              MemtoReg,
    output logic              RegWrite,
    output logic              ALUSrcA,
    output logic [1:0]        ALUSrcB,
    output logic [ALUOPW-1:0] ALUOp,
    output logic [1:0]        PCSource,
    output logic              Shamt,
    output logic              err,
    output logic [3:0]        state_o
);

    state_t     state, next_state;
    ctrl_t      ctrl;
    logic [5:0] op6, fn6;
    logic       waiting, enter_wait, timeout;

    assign op6        = 6'(opcode);
    assign fn6        = 6'(funct);
    assign waiting    = is_wait_state(state);
    assign enter_wait = is_wait_state(next_state) && (next_state != state);

    mem_wait_timer #(.MEM_TIMEOUT(MEM_TIMEOUT), .TOW(TOW)) u_timer (
        .clk       (clk),
        .rst       (rst),
        .waiting   (waiting),
        .clear     (enter_wait),
        .mem_ready (mem_ready),
        .timeout   (timeout)
    );

    always_comb begin
        next_state = S_ERR;
        case (state)
            S_RST:    next_state = S_FETCH;
            S_FETCH:  next_state = mem_ready ? S_DECODE : (timeout ? S_ERR : S_FETCH);
            S_DECODE: begin
                case (op6)
                    OP_R_FORMAT:   next_state = instr_nop ? S_FETCH : S_REXEC;
                    OP_LW, OP_SW:  next_state = S_MEMADR;
                    OP_BEQ, OP_BGTZ: next_state = S_BRANCH;
                    OP_J:          next_state = S_JUMP;
                    OP_ADDIU:      next_state = S_IEXEC;
                    default:       next_state = S_ERR;
                endcase
            end
            S_REXEC:  next_state = S_RWB;
            S_RWB:    next_state = S_FETCH;
            S_MEMADR: next_state = (op6 == OP_LW) ? S_MEMRD : ((op6 == OP_SW) ? S_MEMWR : S_ERR);
            S_MEMRD:  next_state = mem_ready ? S_MEMWB : (timeout ? S_ERR : S_MEMRD);
            S_MEMWB:  next_state = S_FETCH;
            S_MEMWR:  next_state = mem_ready ? S_FETCH : (timeout ? S_ERR : S_MEMWR);
            S_BRANCH: next_state = S_FETCH;
            S_JUMP:   next_state = S_FETCH;
            S_IEXEC:  next_state = S_IWB;
            S_IWB:    next_state = S_FETCH;
            S_ERR:    next_state = S_ERR;
            default:  next_state = S_ERR;
        endcase
    end

    // Controls are registered for the state being entered, so reset clears them at once.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_RST;
            ctrl  <= '0;
        end else begin
            state <= next_state;
            ctrl  <= decode_ctrl(next_state, op6, fn6);
        end
    end

    assign PCWrite     = ctrl.pcwrite | (ctrl.fetch & mem_ready);
    assign IRWrite     = ctrl.fetch & mem_ready;
    assign PCWriteCond = ctrl.pcwritecond;
    assign BrType      = ctrl.brtype;
    assign IorD        = ctrl.iord;
    assign MemRead     = ctrl.memread;
    assign MemWrite    = ctrl.memwrite;
    assign RegDst      = ctrl.regdst;
    assign MemtoReg    = ctrl.memtoreg;
    assign RegWrite    = ctrl.regwrite;
    assign ALUSrcA     = ctrl.alusrca;
    assign ALUSrcB     = ctrl.alusrcb;
    assign ALUOp       = ALUOPW'(ctrl.aluop);
    assign PCSource    = ctrl.pcsource;
    assign Shamt       = ctrl.shamt;
    assign err         = ctrl.err;
    assign state_o     = state;

endmodule

// File: tb/tb_control_multi.sv
// Self-checking bench for control_multi: cycle-count table, directed corner cases
// and random instruction streams checked against a phase-level model.
module tb_control_multi;

    localparam int TIMEOUT_CYCLES = 15;

    typedef enum int {
        P_FETCH, P_DECODE, P_REXEC, P_RWB, P_MEMADR, P_MEMRD, P_MEMWB,
        P_MEMWR, P_BRANCH, P_JUMP, P_IEXEC, P_IWB, P_ERR
    } phase_t;

    typedef struct packed {
        logic       pcw;
        logic       pcwc;
        logic [1:0] brt;
        logic       iord;
        logic       mrd;
        logic       mwr;
        logic       irw;
        logic       regdst;
        logic       memtoreg;
        logic       regw;
        logic       srca;
        logic [1:0] srcb;
        logic [1:0] aluop;
        logic [1:0] pcsrc;
        logic       shamt;
        logic       err;
    } out_t;

    typedef struct {
        phase_t ph;
        bit     rdy;
    } step_t;

    typedef struct {
        logic [5:0] op;
        logic [5:0] fn;
        bit         nop;
        int         cycles;
        string      name;
    } vec_t;

    logic       clk = 1'b0;
    logic       rst;
    logic [5:0] opcode, funct;
    logic       instr_nop, mem_ready;
    logic       PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite;
    logic       RegDst, MemtoReg, RegWrite, ALUSrcA, Shamt, err;
    logic [1:0] BrType, ALUSrcB, ALUOp, PCSource;
    logic [3:0] state_o;

    int    total = 0;
    int    bad   = 0;
    step_t plan[$];
    vec_t  tbl[8];

    control_multi dut (
        .clk(clk), .rst(rst), .opcode(opcode), .funct(funct), .instr_nop(instr_nop),
        .mem_ready(mem_ready), .PCWrite(PCWrite), .PCWriteCond(PCWriteCond), .BrType(BrType),
        .IorD(IorD), .MemRead(MemRead), .MemWrite(MemWrite), .IRWrite(IRWrite),
        .RegDst(RegDst), .MemtoReg(MemtoReg), .RegWrite(RegWrite), .ALUSrcA(ALUSrcA),
        .ALUSrcB(ALUSrcB), .ALUOp(ALUOp), .PCSource(PCSource), .Shamt(Shamt),
        .err(err), .state_o(state_o)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog");
    end

    function automatic out_t sample();
        out_t s;
        s = '{pcw: PCWrite, pcwc: PCWriteCond, brt: BrType, iord: IorD, mrd: MemRead,
              mwr: MemWrite, irw: IRWrite, regdst: RegDst, memtoreg: MemtoReg,
              regw: RegWrite, srca: ALUSrcA, srcb: ALUSrcB, aluop: ALUOp,
              pcsrc: PCSource, shamt: Shamt, err: err};
        return s;
    endfunction

    // Reference: what the datapath should see in each phase of an instruction.
    function automatic out_t expected(phase_t ph, logic [5:0] op, logic [5:0] fn, bit rdy);
        out_t e;
        e = '0;
        case (ph)
            P_FETCH: begin
                e.mrd = 1; e.srcb = 2'b01; e.irw = rdy; e.pcw = rdy;
            end
            P_DECODE: e.srcb = 2'b11;
            P_REXEC, P_RWB: begin
                e.srca = 1; e.aluop = 2'b10;
                e.shamt = (fn == 6'd0 || fn == 6'd2);
                e.srcb  = e.shamt ? 2'b10 : 2'b00;
                if (ph == P_RWB) begin e.regdst = 1; e.regw = 1; end
            end
            P_MEMADR, P_IEXEC: begin e.srca = 1; e.srcb = 2'b10; end
            P_IWB: begin e.srca = 1; e.srcb = 2'b10; e.regw = 1; end
            P_MEMRD: begin e.mrd = 1; e.iord = 1; end
            P_MEMWB: begin e.memtoreg = 1; e.regw = 1; end
            P_MEMWR: begin e.mwr = 1; e.iord = 1; end
            P_BRANCH: begin
                e.srca = 1; e.aluop = 2'b01; e.pcwc = 1; e.pcsrc = 2'b01;
                e.brt = (op == 6'd7) ? 2'b10 : 2'b01;
            end
            P_JUMP: begin e.pcw = 1; e.pcsrc = 2'b10; end
            P_ERR: e.err = 1;
            default: e = '0;
        endcase
        return e;
    endfunction

    function automatic bit is_wait(phase_t ph);
        return ph == P_FETCH || ph == P_MEMRD || ph == P_MEMWR;
    endfunction

    // Appends a memory wait with the given stall count; returns 1 if it ends in ERR.
    function automatic bit add_wait(phase_t ph, int stalls);
        for (int i = 0; i < stalls && i < TIMEOUT_CYCLES; i++) plan.push_back('{ph, 1'b0});
        if (stalls >= TIMEOUT_CYCLES) begin
            repeat (3) plan.push_back('{P_ERR, 1'b0});
            return 1'b1;
        end
        plan.push_back('{ph, 1'b1});
        return 1'b0;
    endfunction

    function automatic void plan_instr(logic [5:0] op, bit nop, int sf, int sm);
        plan.delete();
        if (add_wait(P_FETCH, sf)) return;
        plan.push_back('{P_DECODE, 1'b0});
        case (op)
            6'd0:  if (!nop) begin plan.push_back('{P_REXEC, 1'b0}); plan.push_back('{P_RWB, 1'b0}); end
            6'd35: begin
                plan.push_back('{P_MEMADR, 1'b0});
                if (!add_wait(P_MEMRD, sm)) plan.push_back('{P_MEMWB, 1'b0});
            end
            6'd43: begin
                plan.push_back('{P_MEMADR, 1'b0});
                void'(add_wait(P_MEMWR, sm));
            end
            6'd4, 6'd7: plan.push_back('{P_BRANCH, 1'b0});
            6'd2:       plan.push_back('{P_JUMP, 1'b0});
            6'd9: begin plan.push_back('{P_IEXEC, 1'b0}); plan.push_back('{P_IWB, 1'b0}); end
            default: repeat (3) plan.push_back('{P_ERR, 1'b0});
        endcase
    endfunction

    task automatic checkOut(string name, out_t act, out_t exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got=%h want=%h", name, act, exp);
        end
    endtask

    task automatic checkInt(string name, int act, int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("[TB] FAIL %s: got=%0d want=%0d", name, act, exp);
        end
    endtask

    task automatic runPlan(string tag);
        foreach (plan[i]) begin
            mem_ready = is_wait(plan[i].ph) ? plan[i].rdy : 1'($urandom_range(0, 1));
            @(negedge clk);
            checkOut($sformatf("%s c%0d", tag, i + 1), sample(),
                     expected(plan[i].ph, opcode, funct, mem_ready));
            @(posedge clk);
            #1;
        end
    endtask

    task automatic applyStimulus(logic [5:0] op, logic [5:0] fn, bit nop, int sf, int sm, string tag);
        opcode = op; funct = fn; instr_nop = nop;
        plan_instr(op, nop, sf, sm);
        runPlan(tag);
    endtask

    task automatic doReset(string tag);
        rst = 1'b1;
        #1;
        checkOut({tag, " async"}, sample(), '0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        checkOut({tag, " idle"}, sample(), '0);
        @(posedge clk);
        #1;
    endtask

    // Table entries: instruction fetched with mem_ready held high, measured until the next fetch.
    task automatic checkOutput();
        int n;
        foreach (tbl[k]) begin
            opcode = tbl[k].op; funct = tbl[k].fn; instr_nop = tbl[k].nop; mem_ready = 1'b1;
            n = 1;
            @(posedge clk);
            #1;
            while (!(MemRead && !IorD) && n < 20) begin
                n++;
                @(posedge clk);
                #1;
            end
            checkInt({"cycles ", tbl[k].name}, n, tbl[k].cycles);
        end
    endtask

    initial begin
        logic [5:0] ops[7];
        logic [5:0] op, fn;
        bit         nop;
        int         sf, sm;

        ops = '{6'd0, 6'd35, 6'd43, 6'd4, 6'd7, 6'd2, 6'd9};
        tbl[0] = '{6'd0,  6'd32, 1'b0, 4, "add"};
        tbl[1] = '{6'd9,  6'd0,  1'b0, 4, "addiu"};
        tbl[2] = '{6'd35, 6'd0,  1'b0, 5, "lw"};
        tbl[3] = '{6'd43, 6'd0,  1'b0, 4, "sw"};
        tbl[4] = '{6'd4,  6'd0,  1'b0, 3, "beq"};
        tbl[5] = '{6'd7,  6'd0,  1'b0, 3, "bgtz"};
        tbl[6] = '{6'd2,  6'd0,  1'b0, 3, "j"};
        tbl[7] = '{6'd0,  6'd0,  1'b1, 2, "nop"};

        opcode = '0; funct = '0; instr_nop = 1'b0; mem_ready = 1'b0; rst = 1'b1;
        doReset("por");
        checkOutput();

        applyStimulus(6'd35, 6'd0,  1'b0, 0, 0,  "lw");
        applyStimulus(6'd9,  6'd0,  1'b0, 3, 0,  "fetch_stall3");
        applyStimulus(6'd0,  6'd0,  1'b0, 0, 0,  "sll");
        applyStimulus(6'd0,  6'd2,  1'b0, 0, 0,  "srl");
        applyStimulus(6'd0,  6'd32, 1'b0, 0, 0,  "add");
        applyStimulus(6'd0,  6'd0,  1'b1, 0, 0,  "nop");
        applyStimulus(6'd4,  6'd0,  1'b0, 0, 0,  "beq");
        applyStimulus(6'd7,  6'd0,  1'b0, 0, 0,  "bgtz");
        applyStimulus(6'd2,  6'd0,  1'b0, 0, 0,  "j");
        applyStimulus(6'd43, 6'd0,  1'b0, 0, 14, "sw_edge");
        applyStimulus(6'd35, 6'd0,  1'b0, 14, 14, "lw_edge");

        for (int t = 0; t < 40; t++) begin
            op  = ops[$urandom_range(0, 6)];
            fn  = ($urandom_range(0, 2) == 0) ? 6'($urandom_range(0, 2)) : 6'($urandom_range(0, 63));
            nop = (op == 6'd0) && ($urandom_range(0, 7) == 0);
            if (nop) fn = 6'd0;
            sf  = ($urandom_range(0, 7) == 0) ? 14 : int'($urandom_range(0, 2));
            sm  = ($urandom_range(0, 7) == 0) ? 14 : int'($urandom_range(0, 2));
            applyStimulus(op, fn, nop, sf, sm, $sformatf("rnd%0d op%0d", t, op));
        end

        // Reset while a load is stalled in its memory read.
        opcode = 6'd35; funct = 6'd0; instr_nop = 1'b0;
        plan.delete();
        plan.push_back('{P_FETCH, 1'b1});
        plan.push_back('{P_DECODE, 1'b0});
        plan.push_back('{P_MEMADR, 1'b0});
        plan.push_back('{P_MEMRD, 1'b0});
        runPlan("lw_rst");
        checkOut("lw_rst memrd", sample(), expected(P_MEMRD, opcode, funct, 1'b0));
        doReset("lw_rst");
        mem_ready = 1'b0;
        @(negedge clk);
        checkOut("lw_rst refetch", sample(), expected(P_FETCH, opcode, funct, 1'b0));
        @(posedge clk);
        #1;

        applyStimulus(6'd43, 6'd0, 1'b0, 0, 15, "sw_timeout");
        doReset("sw_timeout");
        applyStimulus(6'd63, 6'd0, 1'b0, 0, 0,  "op63");
        doReset("op63");
        applyStimulus(6'd0,  6'd0, 1'b0, 15, 0, "fetch_timeout");
        doReset("fetch_timeout");
        applyStimulus(6'd9,  6'd5, 1'b0, 1, 0,  "after_err");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
